cla_pipe_add_sub: RTL and testbench

Pipelined, parametrised signed carry-lookahead adder/subtractor with per-transaction add/sub and saturate selection, signed-overflow detection and valid/ready flow control on both sides. The carry chain is split into STAGES equal segments, one register stage each, so wide operands close timing at full clock rate. It is the registered, streaming successor to the combinational `cla_signed_add_sub` and sits between operand producers and the accumulate/DSP datapath.

---
 rtl/cla_pipe_add_sub_pkg.sv | 27 ++
 rtl/cla_pipe_add_sub_if.sv | 33 +++
 rtl/cla_pipe_add_sub_seg.sv | 46 ++++
 rtl/cla_pipe_add_sub.sv | 142 ++++++++++++++
 tb/tb_cla_pipe_add_sub.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pipe_add_sub_pkg.sv
// cla_pkg -- shared helpers for the pipelined carry-lookahead adder/subtractor.
//   gp_combine : merges a higher and a lower generate/propagate pair (CLA operator)
//   sat_max    : most positive two's-complement value of a given width
//   sat_min    : most negative two's-complement value of a given width
//   cfg_legal  : parameter legality (width divisible by stage count, width <= SAT_W)
package cla_pkg;

   localparam int SAT_W = 64;

   function automatic logic [1:0] gp_combine(input logic g_hi, input logic p_hi,
                                             input logic g_lo, input logic p_lo);
      return {g_hi | (p_hi & g_lo), p_hi & p_lo};
   endfunction

   function automatic logic [SAT_W-1:0] sat_max(input int w);
      return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
   endfunction

   function automatic logic [SAT_W-1:0] sat_min(input int w);
      return SAT_W'(1) << (w - 1);
   endfunction

   function automatic bit cfg_legal(input int w, input int s);
      return (s > 0) && (w >= s) && ((w % s) == 0) && (w <= SAT_W);
   endfunction

endpackage

// File: rtl/cla_pipe_add_sub_if.sv
// cla_pipe_add_sub_if -- streaming operand/result bundle for cla_pipe_add_sub.
//   in_valid_i/in_ready_o   : operand beat handshake
//   sub_nadd_i, sat_i       : per-beat operation and saturation select
//   inp_A_i, inp_B_i        : signed operands
//   out_valid_o/out_ready_i : result beat handshake
//   out_o, carry_o, ovf_o   : result, raw MSB carry, signed overflow flag
// modport master : operand producer / result consumer side
// modport slave  : the adder/subtractor block
interface cla_pipe_add_sub_if #(
   parameter int DATA_IN_W = 16
);
   logic                        in_valid_i;
   logic                        in_ready_o;
   logic                        sub_nadd_i;
   logic                        sat_i;
   logic signed [DATA_IN_W-1:0] inp_A_i;
   logic signed [DATA_IN_W-1:0] inp_B_i;
   logic                        out_valid_o;
   logic                        out_ready_i;
   logic signed [DATA_IN_W-1:0] out_o;
   logic                        carry_o;
   logic                        ovf_o;

   modport master (
      output in_valid_i, sub_nadd_i, sat_i, inp_A_i, inp_B_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_o, carry_o, ovf_o
   );

   modport slave (
      input  in_valid_i, sub_nadd_i, sat_i, inp_A_i, inp_B_i, out_ready_i,
      output in_ready_o, out_valid_o, out_o, carry_o, ovf_o
   );
endinterface

// File: rtl/cla_pipe_add_sub_seg.sv
// cla_seg -- combinational SEG_W-bit carry-lookahead slice.
//   a, b  : segment operands (b already conditionally inverted)
//   cin   : carry into the segment
//   sum   : segment sum
//   cout  : carry out of the segment MSB
//   cmsb  : carry into the segment MSB (used for signed overflow in the top slice)
module cla_seg
   import cla_pkg::*;
#(
   parameter int SEG_W = 4
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [SEG_W-1:0] g;
   logic [SEG_W-1:0] p;
   logic [SEG_W:0]   c;
   logic             g_acc;
   logic             p_acc;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is the group generate/propagate of bits [i:0] applied to cin,
   // so no carry waits on the previous sum bit.
   always_comb begin
      c     = '0;
      c[0]  = cin;
      g_acc = 1'b0;
      p_acc = 1'b1;
      for (int i = 0; i < SEG_W; i++) begin
         {g_acc, p_acc} = gp_combine(g[i], p[i], g_acc, p_acc);
         c[i+1]         = g_acc | (p_acc & cin);
      end
   end

   assign sum  = p ^ c[SEG_W-1:0];
   assign cout = c[SEG_W];
   assign cmsb = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_add_sub.sv
// cla_pipe_add_sub -- pipelined signed CLA adder/subtractor with valid/ready flow.
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset, drops every in-flight beat
//   bus   : cla_pipe_add_sub_if slave (operand input, result output)
// Stage k resolves result bits [k*SEG_W +: SEG_W] and registers them together
// with the operands and its carry out; the last stage also evaluates overflow
// and saturation, so every output comes straight from a register.
module cla_pipe_add_sub
   import cla_pkg::*;
#(
   parameter int DATA_IN_W = 16,
   parameter int STAGES    = 4
) (
   input logic             clk_i,
   input logic             rst_i,
   cla_pipe_add_sub_if.slave bus
);

   localparam int SEG_W = DATA_IN_W / STAGES;
   localparam int LAST  = STAGES - 1;

   localparam logic signed [DATA_IN_W-1:0] SAT_MAX = DATA_IN_W'(sat_max(DATA_IN_W));
   localparam logic signed [DATA_IN_W-1:0] SAT_MIN = DATA_IN_W'(sat_min(DATA_IN_W));

   if (!cfg_legal(DATA_IN_W, STAGES)) begin : g_bad_cfg
      $error("cla_pipe_add_sub: DATA_IN_W must be a multiple of STAGES and at most 64");
   end

   function automatic logic signed [DATA_IN_W-1:0] saturate(input logic neg);
      return neg ? SAT_MIN : SAT_MAX;
   endfunction

   logic [STAGES-1:0]           v_p;
   logic [STAGES-1:0]           v_s;
   logic [STAGES-1:0]           en;
   logic [STAGES-1:0]           c_p;
   logic [STAGES-1:0]           c_s;
   logic [STAGES-1:0]           cout;
   logic                        sat_p   [STAGES];
   logic                        sat_s   [STAGES];
   logic                        cmsb    [STAGES];
   logic signed [DATA_IN_W-1:0] a_p     [STAGES];
   logic signed [DATA_IN_W-1:0] b_p     [STAGES];
   logic signed [DATA_IN_W-1:0] sum_p   [STAGES];
   logic signed [DATA_IN_W-1:0] a_s     [STAGES];
   logic signed [DATA_IN_W-1:0] b_s     [STAGES];
   logic signed [DATA_IN_W-1:0] sum_s   [STAGES];
   logic signed [DATA_IN_W-1:0] sum_n   [STAGES];
   logic        [SEG_W-1:0]     seg_sum [STAGES];
   logic signed [DATA_IN_W-1:0] res_n;
   logic                        ovf_n;
   logic                        ovf_p;

   // A stage may load when it is empty or the stage after it is loading too,
   // so bubbles collapse and a full pipe still moves one beat per cycle.
   always_comb begin
      en       = '0;
      en[LAST] = ~v_p[LAST] | bus.out_ready_i;
      for (int k = LAST - 1; k >= 0; k--) begin
         en[k] = ~v_p[k] | en[k+1];
      end
   end

   assign bus.in_ready_o = en[0] & ~rst_i;

   // Stage sources: stage 0 takes the ports (B inverted and cin=1 for subtract),
   // later stages take the previous stage registers.
   always_comb begin
      v_s[0]   = bus.in_valid_i;
      a_s[0]   = bus.inp_A_i;
      b_s[0]   = bus.sub_nadd_i ? ~bus.inp_B_i : bus.inp_B_i;
      c_s[0]   = bus.sub_nadd_i;
      sum_s[0] = '0;
      sat_s[0] = bus.sat_i;
      for (int k = 1; k < STAGES; k++) begin
         v_s[k]   = v_p[k-1];
         a_s[k]   = a_p[k-1];
         b_s[k]   = b_p[k-1];
         c_s[k]   = c_p[k-1];
         sum_s[k] = sum_p[k-1];
         sat_s[k] = sat_p[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_seg #(.SEG_W(SEG_W)) u_seg (
         .a    (a_s[k][k*SEG_W +: SEG_W]),
         .b    (b_s[k][k*SEG_W +: SEG_W]),
         .cin  (c_s[k]),
         .sum  (seg_sum[k]),
         .cout (cout[k]),
         .cmsb (cmsb[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         sum_n[k]                    = sum_s[k];
         sum_n[k][k*SEG_W +: SEG_W]  = seg_sum[k];
      end
   end

   // Last stage: overflow from the two carries around the word MSB; the clamp
   // direction follows the sign of A, which is correct for both add and subtract.
   assign ovf_n = cmsb[LAST] ^ cout[LAST];
   assign res_n = (sat_s[LAST] & ovf_n) ? saturate(a_s[LAST][DATA_IN_W-1]) : sum_n[LAST];

   // ---- stage registers _p[0] .. _p[LAST] ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_p   <= '0;
         c_p   <= '0;
         ovf_p <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_p[k]   <= '0;
            b_p[k]   <= '0;
            sum_p[k] <= '0;
            sat_p[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (en[k]) begin
               v_p[k]   <= v_s[k];
               a_p[k]   <= a_s[k];
               b_p[k]   <= b_s[k];
               sum_p[k] <= (k == LAST) ? res_n : sum_n[k];
               c_p[k]   <= cout[k];
               sat_p[k] <= sat_s[k];
            end
         end
         if (en[LAST]) begin
            ovf_p <= ovf_n;
         end
      end
   end

   assign bus.out_valid_o = v_p[LAST];
   assign bus.out_o       = sum_p[LAST];
   assign bus.carry_o     = c_p[LAST];
   assign bus.ovf_o       = ovf_p;

endmodule

// File: tb/tb_cla_pipe_add_sub.sv
// tb_cla_pipe_add_sub -- directed bench for cla_pipe_add_sub (16 bits, 4 stages).
module tb_cla_pipe_add_sub;

   localparam int W = 16;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_run  = 0;
   int   n_fail = 0;

   cla_pipe_add_sub_if #(.DATA_IN_W(W)) bus ();

   cla_pipe_add_sub #(.DATA_IN_W(W), .STAGES(S)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        sat;
      logic [15:0] o;
      logic        c;
      logic        v;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid_i  = 1'b0;
      bus.sub_nadd_i  = 1'b0;
      bus.sat_i       = 1'b0;
      bus.inp_A_i     = '0;
      bus.inp_B_i     = '0;
      bus.out_ready_i = 1'b1;
   endtask

   // {ovf, carry, out} from a 17-bit sum and operand sign comparison
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic sub, input logic sat);
      logic [15:0] bx;
      logic [16:0] s;
      logic [15:0] r;
      logic        ovf;
      bx  = sub ? ~b : b;
      s   = {1'b0, a} + {1'b0, bx} + 17'(sub);
      r   = s[15:0];
      ovf = (a[15] == bx[15]) && (r[15] != a[15]);
      if (sat && ovf) r = a[15] ? 16'h8000 : 16'h7FFF;
      return {ovf, s[16], r};
   endfunction

   task automatic test_reset();
      logic stale;
      rst = 1'b1;
      idle_inputs();
      #1;
      n_run++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid_o); end
      n_run++; if (bus.out_o !== 16'h0000) begin n_fail++; $display("FAIL rst_out: got %h want 0000", bus.out_o); end
      n_run++; if (bus.carry_o !== 1'b0 || bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got c=%b v=%b want 0 0", bus.carry_o, bus.ovf_o); end
      tick();
      n_run++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready_o); end
      tick();
      rst = 1'b0;
      #1;
      n_run++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", bus.in_ready_o); end
      tick();
      // stream four beats A=i+1, B=1 so the first result (2) is on the output
      for (int i = 0; i < 4; i++) begin
         bus.in_valid_i = 1'b1;
         bus.inp_A_i    = 16'(i + 1);
         bus.inp_B_i    = 16'h0001;
         tick();
      end
      n_run++; if (bus.out_valid_o !== 1'b1 || bus.out_o !== 16'h0002) begin n_fail++; $display("FAIL pre_rst_out: got v=%b %h want v=1 0002", bus.out_valid_o, bus.out_o); end
      rst = 1'b1;
      #1;
      n_run++; if (bus.out_valid_o !== 1'b0 || bus.out_o !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_out: got v=%b %h want v=0 0000", bus.out_valid_o, bus.out_o); end
      n_run++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", bus.in_ready_o); end
      bus.in_valid_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_run++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rel_in_ready: got %b want 1", bus.in_ready_o); end
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.out_valid_o !== 1'b0) stale = 1'b1;
      end
      n_run++; if (stale !== 1'b0) begin n_fail++; $display("FAIL no_stale: got stale=%b want 0", stale); end
   endtask

   task automatic test_arith();
      vec_t vecs [9];
      vecs[0] = '{"add_nov",     16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{"add_wrap0",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{"add_ovf_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
      vecs[4] = '{"sub_ovf_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
      vecs[5] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{"sub_zero",    16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[7] = '{"add_neg_sat", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
      vecs[8] = '{"sub_borrow",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      idle_inputs();
      for (int i = 0; i < 9; i++) begin
         bus.inp_A_i    = vecs[i].a;
         bus.inp_B_i    = vecs[i].b;
         bus.sub_nadd_i = vecs[i].sub;
         bus.sat_i      = vecs[i].sat;
         bus.in_valid_i = 1'b1;
         tick();
         bus.in_valid_i = 1'b0;
         repeat (S - 2) tick();
         n_run++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_early: got valid=%b want 0", vecs[i].name, bus.out_valid_o); end
         tick();
         n_run++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", vecs[i].name, bus.out_valid_o); end
         n_run++; if (bus.out_o !== vecs[i].o) begin n_fail++; $display("FAIL %s_out: got %h want %h", vecs[i].name, bus.out_o, vecs[i].o); end
         n_run++; if (bus.carry_o !== vecs[i].c) begin n_fail++; $display("FAIL %s_carry: got %b want %b", vecs[i].name, bus.carry_o, vecs[i].c); end
         n_run++; if (bus.ovf_o !== vecs[i].v) begin n_fail++; $display("FAIL %s_ovf: got %b want %b", vecs[i].name, bus.ovf_o, vecs[i].v); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_out [8];
      logic [15:0] held;
      logic        stall_prev;
      int          sent, recv, first_drop, first_emit;
      for (int i = 0; i < 8; i++) exp_out[i] = 16'h1000 + 16'(i * 'h0111) + 16'(i);
      idle_inputs();
      sent = 0; recv = 0; first_drop = -1; first_emit = -1;
      stall_prev = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         bus.out_ready_i = !(cyc >= 3 && cyc <= 6);
         bus.in_valid_i  = (sent < 8);
         bus.inp_A_i     = 16'h1000 + 16'(sent * 'h0111);
         bus.inp_B_i     = 16'(sent);
         #1;
         if (sent < 8 && bus.in_ready_o !== 1'b1 && first_drop < 0) first_drop = cyc;
         if (stall_prev) begin
            n_run++;
            if (bus.out_valid_o !== 1'b1 || bus.out_o !== held) begin
               n_fail++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", bus.out_valid_o, bus.out_o, held);
            end
         end
         if (recv > 0) begin
            n_run++;
            if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_gap: got valid=%b want 1 at beat %0d", bus.out_valid_o, recv); end
         end
         if (bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
            if (first_emit < 0) first_emit = cyc;
            n_run++;
            if (bus.out_o !== exp_out[recv]) begin n_fail++; $display("FAIL bp_data%0d: got %h want %h", recv, bus.out_o, exp_out[recv]); end
            recv++;
         end
         if (bus.in_valid_i && bus.in_ready_o === 1'b1) sent++;
         stall_prev = (bus.out_valid_o === 1'b1) && !bus.out_ready_i;
         held       = bus.out_o;
         @(posedge clk);
         #1;
      end
      idle_inputs();
      n_run++; if (recv != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", recv); end
      n_run++; if (first_drop != 4) begin n_fail++; $display("FAIL bp_ready_drop: got cycle %0d want 4", first_drop); end
      n_run++; if (first_emit != 7) begin n_fail++; $display("FAIL bp_first_emit: got cycle %0d want 7", first_emit); end
   endtask

   task automatic test_sweep();
      logic [15:0] va [$];
      logic [15:0] vb [$];
      logic        vs [$];
      logic [17:0] expq [$];
      logic [17:0] got, want;
      int          n, sent, recv, cyc;
      for (int ia = 0; ia < 12; ia++)
         for (int ib = 0; ib < 14; ib++)
            for (int op = 0; op < 2; op++) begin
               va.push_back(16'(-128 + 23 * ia));
               vb.push_back(16'(-128 + 19 * ib));
               vs.push_back(op[0]);
            end
      n = va.size();
      sent = 0; recv = 0; cyc = 0;
      idle_inputs();
      while (recv < n && cyc < 5000) begin
         bus.out_ready_i = ($urandom_range(0, 3) != 0);
         bus.in_valid_i  = (sent < n) && ($urandom_range(0, 4) != 0);
         bus.sat_i       = $urandom_range(0, 1) != 0;
         if (sent < n) begin
            bus.inp_A_i    = va[sent];
            bus.inp_B_i    = vb[sent];
            bus.sub_nadd_i = vs[sent];
         end
         #1;
         if (bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
            got  = {bus.ovf_o, bus.carry_o, bus.out_o};
            want = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
            n_run++;
            if (got !== want) begin n_fail++; $display("FAIL sweep%0d: got %h want %h", recv, got, want); end
            recv++;
         end
         if (bus.in_valid_i && bus.in_ready_o === 1'b1) begin
            expq.push_back(model(va[sent], vb[sent], vs[sent], bus.sat_i));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      idle_inputs();
      n_run++; if (recv != n) begin n_fail++; $display("FAIL sweep_count: got %0d want %0d", recv, n); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_back_to_back();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
